// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM states
// and a small decode helper used by both the top level and the iterative datapath.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD     = 4'b0000,
      OP_XOR     = 4'b0001,
      OP_XORRED  = 4'b0010,
      OP_ADD2    = 4'b0011,
      OP_PASSB   = 4'b0100,
      OP_ADD3    = 4'b0101,
      OP_EQ      = 4'b0110,
      OP_NE      = 4'b0111,
      OP_ADDINC  = 4'b1000,
      OP_SUBINC  = 4'b1001,
      OP_SHL     = 4'b1010,
      OP_SHR     = 4'b1011,
      OP_MUL     = 4'b1100,
      OP_DIV     = 4'b1101,
      OP_RSV0    = 4'b1110,
      OP_RSV1    = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   // Multiply and divide are the only opcodes that need the iterative datapath.
   function automatic logic isMulDiv(input alu_op_e op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply / restoring divide. One partial product or one
// quotient bit is produced per cycle; the final step's value is presented on
// resLo_o/resHi_o together with done_o so the caller can capture it directly.
module seq_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
)(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             isDiv_i,
   input  logic [WIDTH-1:0] opA_i,
   input  logic [WIDTH-1:0] opB_i,
   output logic             done_o,
   output logic [WIDTH-1:0] resLo_o,
   output logic [WIDTH-1:0] resHi_o
);

   logic             busy_q;
   logic             isDiv_q;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] operand_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic [WIDTH:0]   mulSum;
   logic [WIDTH:0]   divShift;
   logic             divGe;
   logic [WIDTH-1:0] nextHi;
   logic [WIDTH-1:0] nextLo;
   logic             lastStep;

   // One iteration step: hi/lo hold product halves for multiply, remainder/quotient for divide.
   // A zero divisor makes every trial subtraction succeed, so the quotient
   // fills with ones and the dividend shifts whole into the remainder.
   always_comb begin
      mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, operand_q} : '0);
      divShift = {hi_q, lo_q[WIDTH-1]};
      divGe    = divShift >= {1'b0, operand_q};
      nextHi   = '0;
      nextLo   = '0;
      if (isDiv_q) begin
         nextHi = divGe ? (divShift[WIDTH-1:0] - operand_q) : divShift[WIDTH-1:0];
         nextLo = {lo_q[WIDTH-2:0], divGe};
      end else begin
         nextHi = mulSum[WIDTH:1];
         nextLo = {mulSum[0], lo_q[WIDTH-1:1]};
      end
   end

   assign lastStep = busy_q && (count_q == CNT_W'(WIDTH - 1));
   assign done_o   = lastStep;
   assign resLo_o  = nextLo;
   assign resHi_o  = nextHi;

   // Load operands on start, then iterate exactly WIDTH times while busy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q    <= 1'b0;
         isDiv_q   <= 1'b0;
         count_q   <= '0;
         operand_q <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else if (start_i) begin
         busy_q    <= 1'b1;
         isDiv_q   <= isDiv_i;
         count_q   <= '0;
         hi_q      <= '0;
         lo_q      <= isDiv_i ? opA_i : opB_i;
         operand_q <= isDiv_i ? opB_i : opA_i;
      end else if (busy_q) begin
         hi_q    <= nextHi;
         lo_q    <= nextLo;
         count_q <= count_q + CNT_W'(1);
         if (lastStep) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes. Single-cycle operations are
// evaluated at accept time; multiply/divide are delegated to seq_muldiv.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [3:0]       alu_cmd,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             rslt_valid,
   input  logic             rslt_ready,
   output logic [WIDTH-1:0] rslt,
   output logic [WIDTH-1:0] rslt_hi,
   output logic             is_zero,
   output logic             carry
);

   alu_state_e       state_q;
   alu_state_e       state_d;
   alu_op_e          cmd;
   logic             accept;

   logic [WIDTH-1:0] rslt_q;
   logic [WIDTH-1:0] rsltHi_q;
   logic             isZero_q;
   logic             carry_q;

   logic [WIDTH:0]   addSum;
   logic [WIDTH:0]   incSum;
   logic [WIDTH:0]   aPlus1;
   logic [WIDTH-1:0] scLo;
   logic             scZero;
   logic             scCarry;

   logic             mdDone;
   logic [WIDTH-1:0] mdLo;
   logic [WIDTH-1:0] mdHi;

   assign cmd    = alu_op_e'(alu_cmd);
   assign accept = start_valid && (state_q == IDLE);

   seq_muldiv #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_muldiv (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .start_i (accept && isMulDiv(cmd)),
      .isDiv_i (cmd == OP_DIV),
      .opA_i   (in_a),
      .opB_i   (in_b),
      .done_o  (mdDone),
      .resLo_o (mdLo),
      .resHi_o (mdHi)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: iterative ops go through EXEC, everything else straight to DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = isMulDiv(cmd) ? EXEC : DONE;
         EXEC: if (mdDone) state_d = DONE;
         DONE: if (rslt_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs depend only on the current state.
   always_comb begin
      start_ready = (state_q == IDLE);
      rslt_valid  = (state_q == DONE);
   end

   // Single-cycle datapath evaluated on the live request operands.
   // Shift amounts and the borrow compare use a+1 at WIDTH+1 bits so a = all-ones does not wrap.
   always_comb begin
      addSum  = {1'b0, in_a} + {1'b0, in_b};
      incSum  = {1'b0, in_b} + {1'b0, in_a} + (WIDTH+1)'(1);
      aPlus1  = {1'b0, in_a} + (WIDTH+1)'(1);
      scLo    = '0;
      scZero  = 1'b0;
      scCarry = 1'b0;
      case (cmd)
         OP_ADD, OP_ADD2, OP_ADD3: begin
            scLo    = addSum[WIDTH-1:0];
            scCarry = addSum[WIDTH];
         end
         OP_XOR:    scLo = in_a ^ in_b;
         OP_XORRED: scLo = {{(WIDTH-1){1'b0}}, ^in_b};
         OP_PASSB:  scLo = in_b;
         OP_EQ:     scZero = (in_a == in_b);
         OP_NE:     scZero = (in_a != in_b);
         OP_ADDINC: begin
            scLo    = incSum[WIDTH-1:0];
            scCarry = incSum[WIDTH];
         end
         OP_SUBINC: begin
            scLo    = in_b - in_a - WIDTH'(1);
            scCarry = (aPlus1 > {1'b0, in_b});
         end
         OP_SHL: scLo = (aPlus1 >= (WIDTH+1)'(WIDTH)) ? '0 : (in_b << aPlus1);
         OP_SHR: scLo = (aPlus1 >= (WIDTH+1)'(WIDTH)) ? '0 : (in_b >> aPlus1);
         default: begin
            scLo    = '0;
            scZero  = 1'b0;
            scCarry = 1'b0;
         end
      endcase
   end

   // Result registers: captured at accept for single-cycle ops, on the last iteration otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rslt_q   <= '0;
         rsltHi_q <= '0;
         isZero_q <= 1'b0;
         carry_q  <= 1'b0;
      end else if (accept) begin
         rslt_q   <= isMulDiv(cmd) ? '0 : scLo;
         rsltHi_q <= '0;
         isZero_q <= isMulDiv(cmd) ? 1'b0 : scZero;
         carry_q  <= isMulDiv(cmd) ? 1'b0 : scCarry;
      end else if ((state_q == EXEC) && mdDone) begin
         rslt_q   <= mdLo;
         rsltHi_q <= mdHi;
         isZero_q <= 1'b0;
         carry_q  <= 1'b0;
      end
   end

   assign rslt    = rslt_q;
   assign rslt_hi = rsltHi_q;
   assign is_zero = isZero_q;
   assign carry   = carry_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu at WIDTH=8, plus hand-written
// sequences for result hold, ignored requests and reset during EXEC.
module tb_seq_alu;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start_valid;
   logic             start_ready;
   logic [3:0]       alu_cmd;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             rslt_valid;
   logic             rslt_ready;
   logic [WIDTH-1:0] rslt;
   logic [WIDTH-1:0] rslt_hi;
   logic             is_zero;
   logic             carry;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [3:0] cmd;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] expLo;
      logic [7:0] expHi;
      logic       expZero;
      logic       expCarry;
      int         expLat;
      bit         hold;
   } vec_t;

   vec_t vecs[$];

   seq_alu #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .alu_cmd     (alu_cmd),
      .in_a        (in_a),
      .in_b        (in_b),
      .rslt_valid  (rslt_valid),
      .rslt_ready  (rslt_ready),
      .rslt        (rslt),
      .rslt_hi     (rslt_hi),
      .is_zero     (is_zero),
      .carry       (carry)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Hard stop in case something never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void addVec(string n, logic [3:0] c, logic [7:0] a, logic [7:0] b,
                                  logic [7:0] lo, logic [7:0] hi, logic z, logic cy,
                                  int lat, bit hold);
      vec_t v;
      v.name = n; v.cmd = c; v.a = a; v.b = b; v.expLo = lo; v.expHi = hi;
      v.expZero = z; v.expCarry = cy; v.expLat = lat; v.hold = hold;
      vecs.push_back(v);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Present a request, scramble inputs after acceptance, measure cycles until rslt_valid.
   task automatic applyStimulus(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                                input bit hold, output int lat);
      @(negedge clk);
      checkOutput("ready_before_accept", {31'd0, start_ready}, 32'd1);
      start_valid = 1'b1;
      alu_cmd     = cmd;
      in_a        = a;
      in_b        = b;
      @(posedge clk);
      #1;
      if (!hold) start_valid = 1'b0;
      alu_cmd = 4'($urandom);
      in_a    = 8'($urandom);
      in_b    = 8'($urandom);
      lat = 1;
      while (!rslt_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (hold) begin
            alu_cmd = 4'($urandom);
            in_a    = 8'($urandom);
            in_b    = 8'($urandom);
         end
      end
      start_valid = 1'b0;
   endtask

   // Take the result and confirm the block is back in IDLE.
   task automatic releaseResult(input string name);
      @(negedge clk);
      rslt_ready = 1'b1;
      @(posedge clk);
      #1;
      rslt_ready = 1'b0;
      checkOutput({name, "_valid_drop"}, {31'd0, rslt_valid}, 32'd0);
      checkOutput({name, "_ready_back"}, {31'd0, start_ready}, 32'd1);
   endtask

   initial begin
      int lat;
      bit seenValid;

      addVec("add_f0_20",   4'b0000, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b0, 1'b1, 1, 1'b0);
      addVec("mul_ff_ff",   4'b1100, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 9, 1'b0);
      addVec("div_64_07",   4'b1101, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 9, 1'b0);
      addVec("div_64_00",   4'b1101, 8'h64, 8'h00, 8'hFF, 8'h64, 1'b0, 1'b0, 9, 1'b0);
      addVec("shl_07_01",   4'b1010, 8'h07, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("subinc_05_03",4'b1001, 8'h05, 8'h03, 8'hFD, 8'h00, 1'b0, 1'b1, 1, 1'b0);
      addVec("xor_a5_0f",   4'b0001, 8'hA5, 8'h0F, 8'hAA, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("xorred_07",   4'b0010, 8'h00, 8'h07, 8'h01, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("xorred_03",   4'b0010, 8'hFF, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("passb_34",    4'b0100, 8'h12, 8'h34, 8'h34, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("eq_same",     4'b0110, 8'h33, 8'h33, 8'h00, 8'h00, 1'b1, 1'b0, 1, 1'b0);
      addVec("ne_same",     4'b0111, 8'h33, 8'h33, 8'h00, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("eq_diff",     4'b0110, 8'h33, 8'h34, 8'h00, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("ne_diff",     4'b0111, 8'h33, 8'h34, 8'h00, 8'h00, 1'b1, 1'b0, 1, 1'b0);
      addVec("addinc_ff_00",4'b1000, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1, 1'b0);
      addVec("addinc_01_02",4'b1000, 8'h01, 8'h02, 8'h04, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("subinc_02_03",4'b1001, 8'h02, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("subinc_ff_ff",4'b1001, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1, 1'b0);
      addVec("shr_00_80",   4'b1011, 8'h00, 8'h80, 8'h40, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("shl_02_01",   4'b1010, 8'h02, 8'h01, 8'h08, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("shr_06_80",   4'b1011, 8'h06, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("shr_ff_ff",   4'b1011, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("rsv_1110",    4'b1110, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("rsv_1111",    4'b1111, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("add2_80_80",  4'b0011, 8'h80, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 1, 1'b0);
      addVec("add3_01_02",  4'b0101, 8'h01, 8'h02, 8'h03, 8'h00, 1'b0, 1'b0, 1, 1'b0);
      addVec("mul_0c_0a",   4'b1100, 8'h0C, 8'h0A, 8'h78, 8'h00, 1'b0, 1'b0, 9, 1'b1);
      addVec("mul_00_ff",   4'b1100, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 9, 1'b0);
      addVec("div_ff_10",   4'b1101, 8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0, 9, 1'b1);
      addVec("div_05_09",   4'b1101, 8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 1'b0, 9, 1'b0);

      // Reset state, checked while reset is held.
      rst_n       = 1'b0;
      start_valid = 1'b0;
      rslt_ready  = 1'b0;
      alu_cmd     = 4'd0;
      in_a        = '0;
      in_b        = '0;
      #12;
      checkOutput("rst_rslt",    {24'd0, rslt},    32'd0);
      checkOutput("rst_rslt_hi", {24'd0, rslt_hi}, 32'd0);
      checkOutput("rst_is_zero", {31'd0, is_zero}, 32'd0);
      checkOutput("rst_carry",   {31'd0, carry},   32'd0);
      checkOutput("rst_valid",   {31'd0, rslt_valid},  32'd0);
      checkOutput("rst_ready",   {31'd0, start_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Table of directed vectors.
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].hold, lat);
         checkOutput({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].expLat));
         checkOutput({vecs[i].name, "_rslt"},    {24'd0, rslt},    {24'd0, vecs[i].expLo});
         checkOutput({vecs[i].name, "_rslt_hi"}, {24'd0, rslt_hi}, {24'd0, vecs[i].expHi});
         checkOutput({vecs[i].name, "_is_zero"}, {31'd0, is_zero}, {31'd0, vecs[i].expZero});
         checkOutput({vecs[i].name, "_carry"},   {31'd0, carry},   {31'd0, vecs[i].expCarry});
         releaseResult(vecs[i].name);
      end

      // Result held in DONE for 5 cycles while inputs and start_valid toggle.
      applyStimulus(4'b0000, 8'hF0, 8'h20, 1'b0, lat);
      checkOutput("hold_latency", 32'(lat), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         start_valid = 1'($urandom);
         alu_cmd     = 4'($urandom);
         in_a        = 8'($urandom);
         in_b        = 8'($urandom);
         @(posedge clk);
         #1;
         checkOutput("hold_valid",   {31'd0, rslt_valid},  32'd1);
         checkOutput("hold_ready",   {31'd0, start_ready}, 32'd0);
         checkOutput("hold_rslt",    {24'd0, rslt},        32'h10);
         checkOutput("hold_rslt_hi", {24'd0, rslt_hi},     32'h00);
         checkOutput("hold_carry",   {31'd0, carry},       32'd1);
      end
      start_valid = 1'b0;
      releaseResult("hold");
      seenValid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (rslt_valid) seenValid = 1'b1;
      end
      checkOutput("hold_no_new_accept", {31'd0, seenValid}, 32'd0);

      // Reset asserted in the middle of a multiply.
      @(negedge clk);
      start_valid = 1'b1;
      alu_cmd     = 4'b1100;
      in_a        = 8'hFF;
      in_b        = 8'hFF;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("midexec_busy", {31'd0, start_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_rslt",    {24'd0, rslt},        32'd0);
      checkOutput("abort_rslt_hi", {24'd0, rslt_hi},     32'd0);
      checkOutput("abort_is_zero", {31'd0, is_zero},     32'd0);
      checkOutput("abort_carry",   {31'd0, carry},       32'd0);
      checkOutput("abort_valid",   {31'd0, rslt_valid},  32'd0);
      checkOutput("abort_ready",   {31'd0, start_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seenValid = 1'b0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (rslt_valid) seenValid = 1'b1;
      end
      checkOutput("abort_no_result", {31'd0, seenValid},   32'd0);
      checkOutput("abort_idle",      {31'd0, start_ready}, 32'd1);

      // A fresh multiply after the abort must run cleanly.
      applyStimulus(4'b1100, 8'hFF, 8'hFF, 1'b0, lat);
      checkOutput("post_abort_latency", 32'(lat), 32'd9);
      checkOutput("post_abort_rslt",    {24'd0, rslt},    32'h01);
      checkOutput("post_abort_rslt_hi", {24'd0, rslt_hi}, 32'hFE);
      releaseResult("post_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start_valid  input  1  request carries a valid command/operands.
REQ-006 SHALL have port start_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port alu_cmd  input  4  operation code.
REQ-008 SHALL have port in_a  input  WIDTH  first operand.
REQ-009 SHALL have port in_b  input  WIDTH  second operand.
REQ-010 SHALL have port rslt_valid  output  1  result outputs are valid.
REQ-011 SHALL have port rslt_ready  input  1  consumer takes the result.
REQ-012 SHALL have port rslt  output  WIDTH  primary result (low product / quotient).
REQ-013 SHALL have port rslt_hi  output  WIDTH  high product / remainder; 0 for all other ops.
REQ-014 SHALL have port is_zero  output  1  compare flag.
REQ-015 SHALL have port carry  output  1  carry-out (adds) / borrow (subtract); 0 otherwise.

Function
REQ-016 SHALL accept a request when start_valid && start_ready, latching alu_cmd, in_a, in_b; operand changes after acceptance have no effect.
REQ-017 SHALL use FSM states IDLE, EXEC, DONE; start_ready = 1 only in IDLE; rslt_valid = 1 only in DONE.
REQ-018 SHALL go IDLE->DONE on accept for single-cycle ops (result visible the cycle after accept, latency 1).
REQ-019 SHALL go IDLE->EXEC on accept for 1100/1101, stay in EXEC exactly WIDTH cycles, then go to DONE (latency WIDTH+1).
REQ-020 SHALL hold all result outputs stable in DONE until rslt_ready = 1, then go to IDLE; no new request is accepted in that same cycle.
REQ-021 Ops 0000/0011/0101: rslt = a+b mod 2^WIDTH, carry = bit WIDTH of sum.
REQ-022 Op 0001: rslt = a^b. Op 0010: rslt = zero-extended XOR-reduction of b. Op 0100: rslt = b.
REQ-023 Op 0110: is_zero = (a==b); op 0111: is_zero = (a!=b); rslt = 0 for both; is_zero = 0 for every other op.
REQ-024 Op 1000: rslt = b+a+1, carry = carry-out of the WIDTH+1-bit sum.
REQ-025 Op 1001: rslt = b-(a+1) mod 2^WIDTH, carry = 1 when a+1 > b (a+1 computed at WIDTH+1 bits).
REQ-026 Op 1010/1011: rslt = b logically shifted left/right by a+1; shift amount >= WIDTH gives rslt = 0.
REQ-027 Op 1100: unsigned shift-add multiply, one partial product per EXEC cycle; {rslt_hi,rslt} = a*b (2*WIDTH bits).
REQ-028 Op 1101: unsigned restoring divide, one quotient bit per EXEC cycle; rslt = a/b, rslt_hi = a%b.
REQ-029 Op 1101 with b = 0: SHALL still take WIDTH EXEC cycles; rslt = all ones, rslt_hi = a.
REQ-030 Undefined opcodes 1110/1111: single-cycle; rslt = 0, rslt_hi = 0, flags 0.
REQ-031 start_valid asserted in EXEC or DONE SHALL be ignored; requester must hold until start_ready.

Reset
REQ-032 rst_n = 0 SHALL force, without clock: state IDLE, counter 0, rslt = 0, rslt_hi = 0, is_zero = 0, carry = 0, rslt_valid = 0, start_ready = 1.
REQ-033 Reset asserted in EXEC or DONE SHALL abort the operation; no result is produced after release.

Structure
REQ-034 Opcode encodings (enum) and FSM state typedef SHALL live in shared package alu_pkg, reused by the decoder.
REQ-035 Multiply/divide datapath SHALL be sub-module seq_muldiv (start, op select, WIDTH-cycle iteration, done); the single-cycle ops remain in seq_alu.

Verification
REQ-036 WIDTH=8: cmd 0000, a=0xF0, b=0x20 -> rslt=0x10, carry=1, rslt_valid one cycle after accept.
REQ-037 cmd 1100, a=0xFF, b=0xFF -> rslt_hi=0xFE, rslt=0x01, rslt_valid exactly 9 cycles after accept.
REQ-038 cmd 1101, a=0x64, b=0x07 -> rslt=0x0E, rslt_hi=0x02; repeat with b=0 -> rslt=0xFF, rslt_hi=0x64.
REQ-039 cmd 1010, a=0x07, b=0x01 -> rslt=0x00; cmd 1001, a=0x05, b=0x03 -> rslt=0xFD, carry=1.
REQ-040 Hold rslt_ready=0 for 5 cycles in DONE while toggling in_a/in_b/start_valid -> outputs stable, no new accept.
REQ-041 Assert rst_n=0 mid-EXEC of a multiply -> all outputs 0, start_ready=1 immediately; no rslt_valid after release.
